// File: rtl/axi_is_pkg.sv
`default_nettype none
// ============================================================================
// Package : axi_is_pkg
// Brief   : Shared AXI constants, writer FSM states and burst-length helper.
// Rev     : 1.0  initial release
// ============================================================================
package axi_is_pkg;

    localparam logic [1:0]  C_AXI_BURST_INCR  = 2'b01;
    localparam logic [3:0]  C_AXI_CACHE_DEF   = 4'b0011;
    localparam logic [1:0]  C_AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0]  C_AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0]  C_AXI_RESP_DECERR = 2'b11;
    localparam logic [12:0] C_4K_BYTES        = 13'h1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } wr_state_t;

    // min(remaining, 2^max_log2, beats left before the next 4 KB page)
    function automatic logic [15:0] burst_beats(
        input logic [11:0] addr_lo,
        input logic [15:0] remaining,
        input int unsigned max_log2,
        input int unsigned beat_log2
    );
        logic [12:0] to_4k;
        logic [15:0] max_len;
        logic [15:0] beats;
        to_4k   = (C_4K_BYTES - {1'b0, addr_lo}) >> beat_log2;
        max_len = 16'd1 << max_log2;
        beats   = remaining;
        if (max_len < beats) beats = max_len;
        if ({3'b000, to_4k} < beats) beats = {3'b000, to_4k};
        return beats;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_is_burst_calc.sv
`default_nettype none
// ============================================================================
// Module : axi_is_burst_calc
// Brief  : Combinational INCR burst splitter (length cap and 4 KB boundary).
// Rev    : 1.0  initial release
// ============================================================================
module axi_is_burst_calc
    import axi_is_pkg::*;
#(
    parameter int unsigned N         = 5,
    parameter int unsigned BEAT_LOG2 = 5
) (
    input  logic [11:0] i_addr_lo,
    input  logic [15:0] i_remaining,
    output logic [15:0] o_beats,
    output logic [7:0]  o_awlen
);

    always_comb begin
        o_beats = burst_beats(i_addr_lo, i_remaining, N, BEAT_LOG2);
        o_awlen = 8'(o_beats - 16'd1);
    end

endmodule
`default_nettype wire

// File: rtl/axi_is_ddr_writer.sv
`default_nettype none
// ============================================================================
// Module : axi_is_ddr_writer
// Brief  : AXI4 write master streaming user data into DDR, one burst in flight.
// Config : AXI_IS_DDR_WRITER_BRESP_CHECK_EN enables the sticky BRESP error flag.
// Rev    : 1.0  initial release
// ============================================================================
module axi_is_ddr_writer
    import axi_is_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int N          = 5,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [ADDR_WIDTH-1:0]     is_dma_waddr,
    input  logic [15:0]               is_dma_wsize,
    input  logic                      is_dma_wareq,
    output logic                      is_dma_wbusy,
    output logic                      is_dma_werr,
    input  logic [DATA_WIDTH-1:0]     is_dma_wdata,
    input  logic                      is_dma_wvalid,
    output logic                      is_dma_wready,
    output logic [ADDR_WIDTH-1:0]     M_AXI_awaddr,
    output logic [7:0]                M_AXI_awlen,
    output logic [2:0]                M_AXI_awsize,
    output logic [1:0]                M_AXI_awburst,
    output logic [3:0]                M_AXI_awcache,
    output logic [ID_WIDTH-1:0]       M_AXI_awid,
    output logic [1:0]                M_AXI_awlock,
    output logic [2:0]                M_AXI_awprot,
    output logic [3:0]                M_AXI_awqos,
    output logic                      M_AXI_awvalid,
    input  logic                      M_AXI_awready,
    output logic [DATA_WIDTH-1:0]     M_AXI_wdata,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_wstrb,
    output logic                      M_AXI_wlast,
    output logic                      M_AXI_wvalid,
    input  logic                      M_AXI_wready,
    input  logic [ID_WIDTH-1:0]       M_AXI_bid,
    input  logic [1:0]                M_AXI_bresp,
    input  logic                      M_AXI_bvalid,
    output logic                      M_AXI_bready
);

    localparam int C_BEAT_LOG2 = $clog2(DATA_WIDTH / 8);

    wr_state_t             r_state;
    wr_state_t             w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [15:0]           r_remaining;
    logic [15:0]           r_beats;
    logic [7:0]            r_awlen;
    logic [7:0]            r_beat_cnt;

    logic                  w_accept;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_b_hs;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic [15:0]           w_rem_next;
    logic [11:0]           w_calc_addr;
    logic [15:0]           w_calc_rem;
    logic [15:0]           w_calc_beats;
    logic [7:0]            w_calc_len;

    assign w_accept    = (r_state == ST_IDLE) && is_dma_wareq && (is_dma_wsize != 16'd0);
    assign w_aw_hs     = M_AXI_awvalid && M_AXI_awready;
    assign w_w_hs      = M_AXI_wvalid && M_AXI_wready;
    assign w_b_hs      = M_AXI_bvalid && M_AXI_bready;
    assign w_addr_next = r_addr + (ADDR_WIDTH'(r_beats) << C_BEAT_LOG2);
    assign w_rem_next  = r_remaining - r_beats;

    // The splitter sees the values the burst registers are about to take, so
    // awaddr/awlen are already valid in the first ADDR cycle.
    assign w_calc_addr = (r_state == ST_IDLE) ? is_dma_waddr[11:0] : w_addr_next[11:0];
    assign w_calc_rem  = (r_state == ST_IDLE) ? is_dma_wsize : w_rem_next;

    axi_is_burst_calc #(
        .N         (N),
        .BEAT_LOG2 (C_BEAT_LOG2)
    ) u_burst_calc (
        .i_addr_lo   (w_calc_addr),
        .i_remaining (w_calc_rem),
        .o_beats     (w_calc_beats),
        .o_awlen     (w_calc_len)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)                   w_state_next = ST_ADDR;
            ST_ADDR: if (M_AXI_awready)              w_state_next = ST_DATA;
            ST_DATA: if (w_w_hs && M_AXI_wlast)      w_state_next = ST_RESP;
            ST_RESP: if (M_AXI_bvalid)
                         w_state_next = (w_rem_next == 16'd0) ? ST_IDLE : ST_ADDR;
            default:                                 w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        is_dma_wbusy  = 1'b1;
        M_AXI_awvalid = 1'b0;
        M_AXI_wvalid  = 1'b0;
        is_dma_wready = 1'b0;
        M_AXI_bready  = 1'b0;
        case (r_state)
            ST_IDLE: is_dma_wbusy  = 1'b0;
            ST_ADDR: M_AXI_awvalid = 1'b1;
            ST_DATA: begin
                M_AXI_wvalid  = is_dma_wvalid;
                is_dma_wready = M_AXI_wready;
            end
            ST_RESP: M_AXI_bready  = 1'b1;
            default: is_dma_wbusy  = 1'b0;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_beats     <= '0;
            r_awlen     <= '0;
            r_beat_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_addr      <= is_dma_waddr;
                r_remaining <= is_dma_wsize;
                r_beats     <= w_calc_beats;
                r_awlen     <= w_calc_len;
            end else if (w_b_hs) begin
                r_addr      <= w_addr_next;
                r_remaining <= w_rem_next;
                if (w_rem_next != 16'd0) begin
                    r_beats <= w_calc_beats;
                    r_awlen <= w_calc_len;
                end
            end
            if (w_aw_hs) begin
                r_beat_cnt <= '0;
            end else if (w_w_hs) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
            end
        end
    end

`ifdef AXI_IS_DDR_WRITER_BRESP_CHECK_EN
    logic r_err;
    logic w_unused;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (w_b_hs && (M_AXI_bresp != C_AXI_RESP_OKAY)) begin
            r_err <= 1'b1;
        end
    end

    assign is_dma_werr = r_err;
    assign w_unused    = ^M_AXI_bid;
`else
    logic w_unused;

    assign is_dma_werr = 1'b0;
    assign w_unused    = ^{M_AXI_bid, M_AXI_bresp};
`endif

    assign M_AXI_awaddr  = r_addr;
    assign M_AXI_awlen   = r_awlen;
    assign M_AXI_awsize  = 3'(C_BEAT_LOG2);
    assign M_AXI_awburst = C_AXI_BURST_INCR;
    assign M_AXI_awcache = C_AXI_CACHE_DEF;
    assign M_AXI_awid    = '0;
    assign M_AXI_awlock  = 2'b00;
    assign M_AXI_awprot  = 3'b000;
    assign M_AXI_awqos   = 4'b0000;
    assign M_AXI_wdata   = is_dma_wdata;
    assign M_AXI_wstrb   = '1;
    assign M_AXI_wlast   = (r_state == ST_DATA) && (r_beat_cnt == r_awlen);

endmodule
`default_nettype wire
